// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned wsel_w(input int unsigned line_w, input int unsigned data_w);
    return $clog2(line_w / data_w);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned line_w,
                                        input int unsigned data_w, input int unsigned sets);
    return addr_w - off_w(data_w) - wsel_w(line_w, data_w) - idx_w(sets);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: combinational read, synchronous single-port write.
module dcache_sram #(
  parameter int unsigned SETS   = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 22,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned WSEL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [DATA_W-1:0] word_data
);

  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tags [SETS];
  logic [LINE_W-1:0] data [SETS];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Line contents and tags are deliberately left out of reset; valid gates them.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end else if (word_we) begin
      data[idx][word_sel*DATA_W +: DATA_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic, miss FSM
// and backing-memory interface.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned OFF_W  = off_w(DATA_W);
  localparam int unsigned WSEL_W = wsel_w(LINE_W, DATA_W);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINE_W, DATA_W, SETS);
  localparam int unsigned LOW_W  = OFF_W + WSEL_W;

  state_t              state;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;

  logic [ADDR_W-1:0]   cur_addr;
  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic [WSEL_W-1:0]   cur_wsel;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic [DATA_W-1:0]   rd_word;
  logic                tag_match, hit, miss;
  logic                line_we, word_we;
  logic [DATA_W-1:0]   word_data;
  logic                unused_ok;

  // Live inputs address the arrays only in IDLE; afterwards the latched request does.
  assign cur_addr  = (state == IDLE) ? addr_i : lat_addr;
  assign cur_idx   = cur_addr[LOW_W +: IDX_W];
  assign cur_tag   = cur_addr[ADDR_W-1 -: TAG_W];
  assign cur_wsel  = cur_addr[OFF_W +: WSEL_W];
  assign unused_ok = &{1'b0, cur_addr[OFF_W-1:0]};

  assign tag_match = rd_valid && (rd_tag == cur_tag);
  assign hit       = (state == IDLE) && req_i && tag_match;
  assign miss      = (state == IDLE) && req_i && !tag_match;
  assign rd_word   = rd_line[cur_wsel*DATA_W +: DATA_W];
  assign line_we   = rst_i && (state == REFILL) && mem_ack_i;
  assign word_we   = rst_i && ((hit && we_i) || ((state == RESPOND) && lat_we));
  assign word_data = (state == IDLE) ? wdata_i : lat_wdata;

  always_comb begin
    stall_o = miss || (state == WRITEBACK) || (state == REFILL);
    rdata_o = '0;
    if ((hit && !we_i) || ((state == RESPOND) && !lat_we)) rdata_o = rd_word;
  end

  dcache_sram #(
    .SETS   (SETS),
    .LINE_W (LINE_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .WSEL_W (WSEL_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (cur_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_tag  (cur_tag),
    .line_data (mem_rdata_i),
    .word_we   (word_we),
    .word_sel  (cur_wsel),
    .word_data (word_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_addr  <= addr_i;
            lat_we    <= we_i;
            lat_wdata <= wdata_i;
            mem_req_o <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state       <= WRITEBACK;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {rd_tag, cur_idx, {LOW_W{1'b0}}};
              mem_wdata_o <= rd_line;
            end else begin
              state      <= REFILL;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {cur_tag, cur_idx, {LOW_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= REFILL;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= {cur_tag, cur_idx, {LOW_W{1'b0}}};
            mem_wdata_o <= '0;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state      <= RESPOND;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table driven through a scoreboard
// against a reference memory model, plus reset-mid-refill and input-change sequences.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_i, we_i;
  logic [31:0]  addr_i, wdata_i, rdata_o;
  logic         stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;

  int passed = 0;
  int total  = 0;

  logic [255:0] bmem [logic [31:0]];
  logic [31:0]  rmem [logic [31:0]];
  logic [31:0]  sb_q [$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          d;
    int          exp_stall;
    bit          exp_wb;
    logic [31:0] wb_addr;
  } vec_t;

  vec_t tbl [15];

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .LINE_W (256),
    .SETS   (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = pat(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [255:0] l;
    if (rmem.exists(a)) return rmem[a];
    l = line_of(a & ~32'h1F);
    return l[a[4:2]*32 +: 32];
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_of(la + 32'(i * 4));
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input int exp_stall, input bit exp_wb,
                           input logic [31:0] wb_addr, input bit chg, input logic [31:0] alt);
    int stalls = 0;
    int rc     = 0;
    bit wb_seen = 1'b0;
    bit done    = 1'b0;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    if (we) rmem[a] = wd;
    else    sb_q.push_back(word_of(a));
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (mem_req_o) begin
        rc++;
        if (rc >= d) begin
          rc = 0;
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            wb_seen = 1'b1;
            chk("wb_addr", {224'd0, mem_addr_o}, {224'd0, wb_addr});
            chk("wb_data", mem_wdata_o, exp_line(wb_addr));
            bmem[mem_addr_o] = mem_wdata_o;
          end else begin
            chk("refill_addr", {224'd0, mem_addr_o}, {224'd0, a & ~32'h1F});
            mem_rdata_i = line_of(mem_addr_o);
          end
        end
      end
      if (!stall_o) begin
        done = 1'b1;
        if (!we) chk("rdata", {224'd0, rdata_o}, {224'd0, sb_q.pop_front()});
      end
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (chg && stalls == 1) begin
        addr_i  = alt;
        wdata_i = ~wd;
      end
    end
    if (!done) begin
      chk("timeout", 256'd0, 256'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    req_i = 1'b0;
    chk("stall_cycles", 256'(stalls), 256'(exp_stall));
    chk("wb_seen", {255'd0, wb_seen}, {255'd0, exp_wb});
  endtask

  initial begin
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    tbl[0]  = '{1'b0, 32'h0000_0040, 32'h0,         3, 4, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0044, 32'h0,         1, 0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0440, 32'h0,         2, 5, 1'b1, 32'h0000_0040};
    tbl[4]  = '{1'b0, 32'h0000_0040, 32'h0,         1, 2, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 1, 2, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_1000, 32'h0,         1, 0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_1004, 32'h0,         1, 0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h0000_101C, 32'hCAFE_F00D, 1, 0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_101C, 32'h0,         1, 0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0FE0, 32'h0,         1, 2, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_1FE0, 32'h0,         1, 2, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h0000_2000, 32'h0,         1, 3, 1'b1, 32'h0000_1000};
    tbl[13] = '{1'b0, 32'h0000_1000, 32'h0,         1, 2, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'hFFFF_FFE0, 32'h0,         1, 2, 1'b0, 32'h0};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall",     {255'd0, stall_o},   256'd0);
    chk("rst_mem_req",   {255'd0, mem_req_o}, 256'd0);
    chk("rst_mem_we",    {255'd0, mem_we_o},  256'd0);
    chk("rst_mem_addr",  {224'd0, mem_addr_o}, 256'd0);
    chk("rst_mem_wdata", mem_wdata_o,         256'd0);
    chk("rst_rdata",     {224'd0, rdata_o},   256'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    for (int i = 0; i < 15; i++)
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].d, tbl[i].exp_stall,
                tbl[i].exp_wb, tbl[i].wb_addr, 1'b0, 32'h0);

    // Address changes while stalled must not redirect the refill or the reply.
    do_access(1'b0, 32'h0000_3040, 32'h0, 2, 3, 1'b0, 32'h0, 1'b1, 32'h0000_0044);

    // Reset during REFILL, followed by a stray ack.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_5040;
    begin
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
        @(negedge clk_i);
        if (mem_req_o && !mem_we_o) seen = 1'b1;
        else begin
          @(posedge clk_i);
          #1;
        end
      end
      chk("reach_refill", {255'd0, seen}, 256'd1);
    end
    rst_i = 1'b0; req_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_mem_req", {255'd0, mem_req_o}, 256'd0);
    chk("midrst_stall",   {255'd0, stall_o},   256'd0);
    mem_ack_i = 1'b1; mem_rdata_i = {8{32'hBAD0_BAD0}};
    @(posedge clk_i);
    #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_mem_req", {255'd0, mem_req_o}, 256'd0);
    chk("late_ack_stall",   {255'd0, stall_o},   256'd0);
    @(posedge clk_i);
    #1;
    rmem.delete();

    do_access(1'b0, 32'h0000_5040, 32'h0, 1, 2, 1'b0, 32'h0, 1'b0, 32'h0);
    do_access(1'b0, 32'h0000_0040, 32'h0, 1, 2, 1'b0, 32'h0, 1'b0, 32'h0);
    do_access(1'b0, 32'h0000_101C, 32'h0, 2, 3, 1'b0, 32'h0, 1'b0, 32'h0);

    chk("scoreboard_empty", 256'(sb_q.size()), 256'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
